// File: rtl/des_pkg.sv
// DES constants shared by the encrypt and decrypt datapaths: permutation tables,
// key shift schedule, S-box contents, FSM encoding and the table-driven permute helpers.
package des_pkg;

    typedef logic [1:0] des_state_t;
    localparam des_state_t ST_IDLE  = 2'd0;
    localparam des_state_t ST_ROUND = 2'd1;
    localparam des_state_t ST_DONE  = 2'd2;

    // Tables use DES numbering: entry j gives the 1-based source bit, bit 1 = MSB.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int E_T [48]  = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,
                                  8, 9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32]  = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                  2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                  10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                  63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                  14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10,
                                  23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};

    // Left-rotation schedule of the encrypt key path; decryption walks it backwards.
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // S1..S8, 64 nibbles each, row-major (row = outer bits, column = inner four).
    localparam logic [255:0] SBOX_T [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input int n);
        return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic key_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^k[8*b +: 8]);
        return ok;
    endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Request/response bundle of the DES decrypt engine: ciphertext+key in, plaintext+key_err out,
// each direction with its own valid/ready pair. master = producer/consumer, slave = engine.
interface des_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;
    logic        key_err;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, key_err
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, key_err
    );
endinterface

// File: rtl/des_f_function.sv
// DES round function f(R, K): expansion, subkey XOR, S1..S8, P permutation.
// Purely combinational; shared between the encrypt and decrypt datapaths.
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);
    logic [47:0] e_xor;
    logic [31:0] s_out;

    assign e_xor = e_expand(r_i) ^ k_i;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox #(.IDX(g)) u_sbox (
            .x_i (e_xor[47 - 6*g -: 6]),
            .y_o (s_out[31 - 4*g -: 4])
        );
    end

    assign f_o = p_perm(s_out);
endmodule

// File: rtl/des_sbox.sv
// One DES S-box selected by IDX (0 = S1); combinational 6-to-4 lookup.
module des_sbox
    import des_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [5:0] x_i,
    output logic [3:0] y_o
);
    localparam logic [255:0] TBL = SBOX_T[IDX];

    logic [5:0] ent;

    assign ent = {x_i[5], x_i[0], x_i[4:1]};
    assign y_o = TBL[8'd255 - {ent, 2'b00} -: 4];
endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor, one round per clock; DES_KEY_PARITY_EN adds a key parity check.
// Result 16 cycles after accept, held in DONE until out_ready; no new block accepted meanwhile.
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    des_decrypt_iter_if.slave bus
);
    des_state_t  state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] plaintext_q, plaintext_d;
    logic        key_err_q, key_err_d;
    logic        par_err_q, par_err_d;
    logic        key_bad;
    logic [47:0] subkey;
    logic [31:0] f_out;
    logic [3:0]  shift_idx;

`ifdef DES_KEY_PARITY_EN
    assign key_bad = !key_parity_ok(bus.key);
`else
    assign key_bad = 1'b0;
`endif

    // Starting from PC-1 directly yields K16, since the 16 encrypt rotations total 28.
    assign subkey    = pc2_perm({c_q, d_q});
    assign shift_idx = 4'(5'd16 - rnd_q);

    des_f_function u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        plaintext_d = plaintext_q;
        key_err_d   = key_err_q;
        par_err_d   = par_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    {l_d, r_d} = ip_perm(bus.ciphertext);
                    {c_d, d_d} = pc1_perm(bus.key);
                    rnd_d      = 5'd1;
                    par_err_d  = key_bad;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d = r_q;
                r_d = l_q ^ f_out;
                if (rnd_q == 5'd16) begin
                    // Pre-output is R16||L16, i.e. the halves undo the last swap.
                    plaintext_d = par_err_q ? 64'd0 : fp_perm({l_q ^ f_out, r_q});
                    key_err_d   = par_err_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                    c_d   = ror28(c_q, SHIFT_T[shift_idx]);
                    d_d   = ror28(d_q, SHIFT_T[shift_idx]);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            plaintext_q <= '0;
            key_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            plaintext_q <= plaintext_d;
            key_err_q   <= key_err_d;
            par_err_q   <= par_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = plaintext_q;
    assign bus.key_err   = key_err_q;
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed-vector bench for des_decrypt_iter: known DES answers, latency, backpressure,
// mid-round reset, key parity and back-to-back throughput.
module tb_des_decrypt_iter;
    localparam logic [63:0] K1   = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1   = 64'h85E813540F0AB405;
    localparam logic [63:0] P1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2   = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2   = 64'h0000000000000000;
    localparam logic [63:0] P2   = 64'h8787878787878787;
    localparam logic [63:0] KBAD = 64'h123457799BBCDFF1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    des_decrypt_iter_if dut_if ();

    des_decrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    task automatic send_block(input logic [63:0] ct, input logic [63:0] k);
        int n;
        n = 0;
        while (dut_if.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        dut_if.ciphertext = ct;
        dut_if.key        = k;
        dut_if.in_valid   = 1'b1;
        @(posedge clk); #1;
        dut_if.in_valid   = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (dut_if.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out();
        dut_if.out_ready = 1'b1;
        @(posedge clk); #1;
        dut_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", dut_if.in_ready); end
        checks++;
        if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", dut_if.out_valid); end
        checks++;
        if (dut_if.plaintext !== 64'd0) begin errors++; $display("FAIL reset_plaintext got %h want 0", dut_if.plaintext); end
        checks++;
        if (dut_if.key_err !== 1'b0) begin errors++; $display("FAIL reset_key_err got %b want 0", dut_if.key_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dut_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", dut_if.in_ready); end
    endtask

    task automatic test_vec1();
        int lat;
        send_block(C1, K1);
        checks++;
        if (dut_if.in_ready !== 1'b0) begin errors++; $display("FAIL vec1_busy_in_ready got %b want 0", dut_if.in_ready); end
        wait_out(lat);
        checks++;
        if (lat != 16) begin errors++; $display("FAIL vec1_latency got %0d want 16", lat); end
        checks++;
        if (dut_if.plaintext !== P1) begin errors++; $display("FAIL vec1_plaintext got %h want %h", dut_if.plaintext, P1); end
        checks++;
        if (dut_if.key_err !== 1'b0) begin errors++; $display("FAIL vec1_key_err got %b want 0", dut_if.key_err); end
        release_out();
        checks++;
        if (dut_if.out_valid !== 1'b0 || dut_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL vec1_release got out_valid=%b in_ready=%b want 0/1", dut_if.out_valid, dut_if.in_ready);
        end
    endtask

    task automatic test_vec2();
        int lat;
        send_block(C2, K2);
        wait_out(lat);
        checks++;
        if (lat != 16) begin errors++; $display("FAIL vec2_latency got %0d want 16", lat); end
        checks++;
        if (dut_if.plaintext !== P2) begin errors++; $display("FAIL vec2_plaintext got %h want %h", dut_if.plaintext, P2); end
        checks++;
        if (dut_if.key_err !== 1'b0) begin errors++; $display("FAIL vec2_key_err got %b want 0", dut_if.key_err); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        send_block(C1, K1);
        wait_out(lat);
        // Offer another block while the result is stalled; it must wait for IDLE.
        dut_if.ciphertext = C2;
        dut_if.key        = K2;
        dut_if.in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut_if.plaintext !== P1 || dut_if.in_ready !== 1'b0 || dut_if.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got pt=%h in_ready=%b out_valid=%b want %h/0/1",
                         i, dut_if.plaintext, dut_if.in_ready, dut_if.out_valid, P1);
            end
            @(posedge clk); #1;
        end
        release_out();
        checks++;
        if (dut_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready got %b want 1", dut_if.in_ready); end
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        wait_out(lat);
        checks++;
        if (lat != 16) begin errors++; $display("FAIL bp_next_latency got %0d want 16", lat); end
        checks++;
        if (dut_if.plaintext !== P2) begin errors++; $display("FAIL bp_next_plaintext got %h want %h", dut_if.plaintext, P2); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        send_block(C2, K2);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_if.in_ready !== 1'b0 || dut_if.out_valid !== 1'b0 ||
            dut_if.plaintext !== 64'd0 || dut_if.key_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got in_ready=%b out_valid=%b pt=%h key_err=%b want 0/0/0/0",
                     dut_if.in_ready, dut_if.out_valid, dut_if.plaintext, dut_if.key_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(C1, K1);
        wait_out(lat);
        checks++;
        if (lat != 16) begin errors++; $display("FAIL midreset_latency got %0d want 16", lat); end
        checks++;
        if (dut_if.plaintext !== P1) begin errors++; $display("FAIL midreset_plaintext got %h want %h", dut_if.plaintext, P1); end
        release_out();
    endtask

    task automatic test_parity();
        int lat;
        logic [63:0] exp_pt;
        logic        exp_err;
`ifdef DES_KEY_PARITY_EN
        exp_pt  = 64'd0;
        exp_err = 1'b1;
`else
        exp_pt  = P1;
        exp_err = 1'b0;
`endif
        send_block(C1, KBAD);
        wait_out(lat);
        checks++;
        if (lat != 16) begin errors++; $display("FAIL parity_latency got %0d want 16", lat); end
        checks++;
        if (dut_if.key_err !== exp_err) begin errors++; $display("FAIL parity_key_err got %b want %b", dut_if.key_err, exp_err); end
        checks++;
        if (dut_if.plaintext !== exp_pt) begin errors++; $display("FAIL parity_plaintext got %h want %h", dut_if.plaintext, exp_pt); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [63:0] kv [3];
        logic [63:0] cv [3];
        logic [63:0] pv [3];
        int          acc [3];
        int          idx;
        int          oidx;
        logic        take;
        kv = '{K1, K2, K1};
        cv = '{C1, C2, C1};
        pv = '{P1, P2, P1};
        acc = '{0, 0, 0};
        idx = 0;
        oidx = 0;
        dut_if.out_ready  = 1'b1;
        dut_if.ciphertext = cv[0];
        dut_if.key        = kv[0];
        dut_if.in_valid   = 1'b1;
        for (int n = 0; n < 120 && (idx < 3 || oidx < 3); n++) begin
            take = dut_if.in_ready && dut_if.in_valid && (idx < 3);
            if (take) acc[idx] = n;
            if (dut_if.out_valid === 1'b1 && oidx < 3) begin
                checks++;
                if (dut_if.plaintext !== pv[oidx]) begin
                    errors++;
                    $display("FAIL b2b_plaintext block %0d got %h want %h", oidx, dut_if.plaintext, pv[oidx]);
                end
                oidx++;
            end
            @(posedge clk); #1;
            if (take) begin
                idx++;
                if (idx < 3) begin
                    dut_if.ciphertext = cv[idx];
                    dut_if.key        = kv[idx];
                end else begin
                    dut_if.in_valid = 1'b0;
                end
            end
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b0;
        checks++;
        if (oidx != 3) begin errors++; $display("FAIL b2b_results got %0d want 3", oidx); end
        checks++;
        if (acc[1] - acc[0] != 18) begin errors++; $display("FAIL b2b_spacing_1 got %0d want 18", acc[1] - acc[0]); end
        checks++;
        if (acc[2] - acc[1] != 18) begin errors++; $display("FAIL b2b_spacing_2 got %0d want 18", acc[2] - acc[1]); end
    endtask

    initial begin
        dut_if.in_valid   = 1'b0;
        dut_if.ciphertext = '0;
        dut_if.key        = '0;
        dut_if.out_ready  = 1'b0;
        test_reset();
        test_vec1();
        test_vec2();
        test_backpressure();
        test_reset_mid();
        test_parity();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
